// File: rtl/ram_rom_mem.sv
// ram_rom_mem: registered-read memory with a read-only ROM region in the low
// addresses and writable RAM above it. After reset or a restore command, an
// init engine writes the ROM table and then zero fill, one word per cycle.
module ram_rom_mem #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROM_WORDS  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  restore,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  busy,
  output logic                  wr_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  // Init counter has one extra bit so the terminal compare never wraps.
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] LAST_ADDR = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ROM_LIMIT = CW'(ROM_WORDS);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   dout_d;
  logic                    dout_valid_d;
  logic                    busy_d;
  logic                    wr_err_d;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    addr_in_rom;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Init contents: ROM table (repeated via the low two bits) below ROM_WORDS, zero above.
  function automatic logic [DATA_WIDTH-1:0] init_word(input logic [CW-1:0] a);
    logic [3:0] t;
    case (a[1:0])
      2'd0:    t = 4'b0100;
      2'd1:    t = 4'b1100;
      2'd2:    t = 4'b0110;
      default: t = 4'b0111;
    endcase
    if (a < ROM_LIMIT) begin
      return DATA_WIDTH'(t);
    end
    return '0;
  endfunction

  assign mem_rdata   = mem[addr];
  assign addr_in_rom = ({1'b0, addr} < ROM_LIMIT);

  // Storage array: single write port shared by the init engine and user writes.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b1;
      wr_err     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dout       <= dout_d;
      dout_valid <= dout_valid_d;
      busy       <= busy_d;
      wr_err     <= wr_err_d;
    end
  end

  // Next-state, write-port and output logic. Read-first: dout samples the old word.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dout_d       = dout;
    dout_valid_d = 1'b0;
    busy_d       = busy;
    wr_err_d     = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;

    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[ADDR_WIDTH-1:0];
        mem_wdata = init_word(cnt_q);
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
        end
      end

      default: begin
        if (restore) begin
          state_d = ST_INIT;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          if (re) begin
            dout_d       = mem_rdata;
            dout_valid_d = 1'b1;
          end
          if (we) begin
            if (addr_in_rom) begin
              wr_err_d = 1'b1;
            end else begin
              mem_we    = 1'b1;
              mem_waddr = addr;
              mem_wdata = din;
            end
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_ram_rom_mem.sv
// Testbench for ram_rom_mem: table-driven read/write vectors plus hand-written
// init, restore and mid-init reset sequences.
module tb_ram_rom_mem;

  logic       clock = 1'b0;
  logic       reset;
  logic       restore;
  logic       re;
  logic       we;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_valid;
  logic       busy;
  logic       wr_err;

  int errors = 0;
  int checks = 0;

  ram_rom_mem #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .ROM_WORDS(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .restore    (restore),
    .re         (re),
    .we         (we),
    .addr       (addr),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .wr_err     (wr_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       re;
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic       exp_valid;
    logic       chk_dout;
    logic [7:0] exp_dout;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic w, logic [3:0] a, logic [7:0] d,
                              logic ev, logic cd, logic [7:0] ed, logic ee);
    vec_t v;
    v.re = r; v.we = w; v.addr = a; v.din = d;
    v.exp_valid = ev; v.chk_dout = cd; v.exp_dout = ed; v.exp_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts sampled cycles with busy=1; optionally pulses restore at one sample.
  task automatic count_busy(input int restore_at, output int n, output int valid_seen);
    n = 0;
    valid_seen = 0;
    while (busy === 1'b1 && n < 100) begin
      if (dout_valid === 1'b1) valid_seen++;
      restore = (n == restore_at);
      n++;
      tick();
    end
    restore = 1'b0;
  endtask

  function automatic logic [7:0] init_val(int a);
    logic [7:0] t [4];
    t[0] = 8'h04; t[1] = 8'h0C; t[2] = 8'h06; t[3] = 8'h07;
    return (a < 4) ? t[a] : 8'h00;
  endfunction

  task automatic read_word(input logic [3:0] a, input logic [7:0] exp, input string name);
    re = 1'b1; we = 1'b0; addr = a;
    tick();
    re = 1'b0;
    check({name, "_valid"}, 32'(dout_valid), 32'd1);
    check({name, "_dout"}, 32'(dout), 32'(exp));
  endtask

  task automatic check_init_contents(input string tag);
    for (int a = 0; a < 16; a++) begin
      read_word(4'(a), init_val(a), $sformatf("%s_rd%0d", tag, a));
    end
    tick();
    check({tag, "_valid_drop"}, 32'(dout_valid), 32'd0);
  endtask

  initial begin
    int n;
    int vs;

    reset = 1'b1; restore = 1'b0; re = 1'b0; we = 1'b0; addr = '0; din = '0;
    tick();
    tick();
    check("rst_busy",  32'(busy), 32'd1);
    check("rst_dout",  32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_err",   32'(wr_err), 32'd0);

    // Scenario 1: init length and contents; reads during init are ignored.
    reset = 1'b0;
    re = 1'b1; addr = 4'd3;
    count_busy(-1, n, vs);
    re = 1'b0;
    check("init_busy_cycles", 32'(n), 32'd16);
    check("init_no_valid", 32'(vs), 32'd0);
    check("init_dout_held", 32'(dout), 32'd0);
    check_init_contents("s1");

    // Table-driven vectors after init.
    vecs.push_back(mk(0, 1, 4'd5,  8'hA5, 0, 0, 8'h00, 0)); // write RAM
    vecs.push_back(mk(1, 0, 4'd5,  8'h00, 1, 1, 8'hA5, 0)); // read it back
    vecs.push_back(mk(0, 1, 4'd2,  8'hFF, 0, 0, 8'h00, 1)); // ROM write rejected
    vecs.push_back(mk(0, 0, 4'd0,  8'h00, 0, 1, 8'hA5, 0)); // err pulse ends, dout holds
    vecs.push_back(mk(1, 0, 4'd2,  8'h00, 1, 1, 8'h06, 0)); // ROM intact
    vecs.push_back(mk(0, 1, 4'd3,  8'h12, 0, 0, 8'h00, 1)); // top ROM word
    vecs.push_back(mk(0, 1, 4'd4,  8'h5A, 0, 0, 8'h00, 0)); // first RAM word
    vecs.push_back(mk(1, 0, 4'd4,  8'h00, 1, 1, 8'h5A, 0));
    vecs.push_back(mk(0, 1, 4'd9,  8'h3C, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 1, 4'd9,  8'h77, 1, 1, 8'h3C, 0)); // read-first
    vecs.push_back(mk(1, 0, 4'd9,  8'h00, 1, 1, 8'h77, 0));
    vecs.push_back(mk(0, 0, 4'd9,  8'h00, 0, 1, 8'h77, 0)); // idle: dout holds
    vecs.push_back(mk(1, 1, 4'd5,  8'h00, 1, 1, 8'hA5, 0)); // same-edge read 5...
    vecs.push_back(mk(1, 1, 4'd10, 8'h55, 1, 1, 8'h00, 0)); // ...write 5=0, read 10 old
    vecs.push_back(mk(1, 0, 4'd5,  8'h00, 1, 1, 8'h00, 0));
    vecs.push_back(mk(1, 0, 4'd10, 8'h00, 1, 1, 8'h55, 0));
    vecs.push_back(mk(1, 1, 4'd1,  8'h99, 1, 1, 8'h0C, 1)); // read ROM + rejected write
    vecs.push_back(mk(1, 0, 4'd1,  8'h00, 1, 1, 8'h0C, 0));
    vecs.push_back(mk(0, 1, 4'd15, 8'hEE, 0, 0, 8'h00, 0)); // highest address
    vecs.push_back(mk(1, 0, 4'd15, 8'h00, 1, 1, 8'hEE, 0));
    vecs.push_back(mk(0, 1, 4'd7,  8'h11, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 0, 4'd7,  8'h00, 1, 1, 8'h11, 0));

    foreach (vecs[i]) begin
      re = vecs[i].re; we = vecs[i].we; addr = vecs[i].addr; din = vecs[i].din;
      tick();
      re = 1'b0; we = 1'b0;
      check($sformatf("vec%0d_valid", i), 32'(dout_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_err", i), 32'(wr_err), 32'(vecs[i].exp_err));
      if (vecs[i].chk_dout) begin
        check($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
      end
    end

    // Scenario 5: restore with simultaneous re/we is swallowed, then a full re-init.
    restore = 1'b1; re = 1'b1; we = 1'b1; addr = 4'd8; din = 8'hC3;
    tick();
    restore = 1'b0; we = 1'b0;
    addr = 4'd7;
    check("rs_busy", 32'(busy), 32'd1);
    check("rs_valid", 32'(dout_valid), 32'd0);
    check("rs_err", 32'(wr_err), 32'd0);
    count_busy(6, n, vs); // restore mid-init must not restart the count
    re = 1'b0;
    check("rs_busy_cycles", 32'(n), 32'd16);
    check("rs_no_valid", 32'(vs), 32'd0);
    check("rs_dout_held", 32'(dout), 32'h11);
    read_word(4'd7, 8'h00, "rs_rd7");
    read_word(4'd8, 8'h00, "rs_rd8");
    read_word(4'd2, 8'h06, "rs_rd2");

    // Scenario 6: reset in init cycle 8 clears outputs immediately, then a full init.
    restore = 1'b1;
    tick();
    restore = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_valid", 32'(dout_valid), 32'd0);
    tick();
    reset = 1'b0;
    count_busy(-1, n, vs);
    check("mid_busy_cycles", 32'(n), 32'd16);
    check_init_contents("s6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
